// File: rtl/input_irq_pkg.sv
// ----------------------------------------------------------------------------
// input_irq_pkg
//   Shared definitions for the user-input interrupt controller:
//   - Avalon-MM word addresses of the register file.
//   - clog2 helper used to size the debounce counters.
// ----------------------------------------------------------------------------
package input_irq_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MASK     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd2;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_RAW      = 3'd5;

  // Ceiling log2, usable in constant expressions. clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/input_irq_controller_debounce.sv
// ----------------------------------------------------------------------------
// input_debounce
//   Single-bit metastability synchroniser followed by a debouncer. A new level
//   is accepted only after the synchronised input has differed from the
//   current debounced level for DEBOUNCE_CYCLES consecutive clocks.
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   din      raw asynchronous input level
//   sync     synchronised, undebounced level
//   level    debounced level
// ----------------------------------------------------------------------------
module input_debounce
  import input_irq_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync,
  output logic level
);

  // A one-cycle debounce never needs to count, but the counter still needs
  // a legal width.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // NOTE: every flop is written with <= so all registers update from
  // pre-edge values; blocking assignments here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  // The counter measures how long sync has disagreed with the accepted
  // level; any cycle of agreement restarts the measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync != level) begin
      if (cnt == CNT_LAST) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/input_irq_controller.sv
// ----------------------------------------------------------------------------
// input_irq_controller
//   Synchronises and debounces NUM_INPUTS user inputs ({keys, switches}),
//   captures enabled rising/falling edges into a sticky register and raises a
//   maskable level interrupt. Software access is through an Avalon-MM slave
//   with readLatency = 1.
//
//   Word map: 0 DATA (RO), 1 MASK, 2 EDGE_CAP (W1C), 3 RISE_EN, 4 FALL_EN,
//             5 RAW (RO), 6-7 reserved (read 0). Bits above NUM_INPUTS read 0.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   inputs         raw asynchronous key/switch levels
//   avl_address    word address
//   avl_read       read strobe
//   avl_write      write strobe
//   avl_writedata  write data
//   avl_readdata   registered read data, valid one cycle after avl_read
//   avl_irq        registered level interrupt, active high
// ----------------------------------------------------------------------------
module input_irq_controller
  import input_irq_pkg::*;
#(
  parameter int NUM_INPUTS      = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_INPUTS-1:0] inputs,
  input  logic [2:0]            avl_address,
  input  logic                  avl_read,
  input  logic                  avl_write,
  input  logic [31:0]           avl_writedata,
  output logic [31:0]           avl_readdata,
  output logic                  avl_irq
);

  logic [NUM_INPUTS-1:0] raw;
  logic [NUM_INPUTS-1:0] level;
  logic [NUM_INPUTS-1:0] level_d;
  logic [NUM_INPUTS-1:0] mask;
  logic [NUM_INPUTS-1:0] edge_cap;
  logic [NUM_INPUTS-1:0] rise_en;
  logic [NUM_INPUTS-1:0] fall_en;
  logic [NUM_INPUTS-1:0] capture;
  logic [NUM_INPUTS-1:0] w1c;
  logic [NUM_INPUTS-1:0] wdata;
  logic [31:0]           rd_mux;

  // Write data bits beyond NUM_INPUTS are ignored by design.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, avl_writedata};

  assign wdata = avl_writedata[NUM_INPUTS-1:0];

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_input
    input_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (inputs[i]),
      .sync   (raw[i]),
      .level  (level[i])
    );
  end

  // Edges are taken from the debounced level only, so enabling an edge type
  // later never reports an edge that happened before the enable.
  assign capture = (level & ~level_d & rise_en) | (~level & level_d & fall_en);
  assign w1c     = (avl_write && avl_address == ADDR_EDGE_CAP) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_d  <= '0;
      edge_cap <= '0;
      mask     <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      avl_irq  <= 1'b0;
    end else begin
      level_d  <= level;
      // Capture is OR-ed in after the clear so a same-cycle edge survives W1C.
      edge_cap <= (edge_cap & ~w1c) | capture;
      avl_irq  <= |(edge_cap & mask);
      if (avl_write) begin
        unique case (avl_address)
          ADDR_MASK:    mask    <= wdata;
          ADDR_RISE_EN: rise_en <= wdata;
          ADDR_FALL_EN: fall_en <= wdata;
          default:      ;
        endcase
      end
    end
  end

  // NOTE: rd_mux gets a full default before the case so that unlisted
  // addresses and unused upper bits cannot infer a latch.
  always_comb begin
    rd_mux = '0;
    unique case (avl_address)
      ADDR_DATA:     rd_mux[NUM_INPUTS-1:0] = level;
      ADDR_MASK:     rd_mux[NUM_INPUTS-1:0] = mask;
      ADDR_EDGE_CAP: rd_mux[NUM_INPUTS-1:0] = edge_cap;
      ADDR_RISE_EN:  rd_mux[NUM_INPUTS-1:0] = rise_en;
      ADDR_FALL_EN:  rd_mux[NUM_INPUTS-1:0] = fall_en;
      ADDR_RAW:      rd_mux[NUM_INPUTS-1:0] = raw;
      default:       rd_mux = '0;
    endcase
  end

  // Read data samples register state before any same-cycle write lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avl_readdata <= '0;
    end else if (avl_read) begin
      avl_readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_input_irq_controller.sv
module tb_input_irq_controller;

  localparam int N = 6;

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_MASK = 3'd1;
  localparam logic [2:0] A_EDGE = 3'd2;
  localparam logic [2:0] A_RISE = 3'd3;
  localparam logic [2:0] A_FALL = 3'd4;
  localparam logic [2:0] A_RAW  = 3'd5;

  logic          clk;
  logic          reset_n;
  logic [N-1:0]  inputs;
  logic [2:0]    avl_address;
  logic          avl_read;
  logic          avl_write;
  logic [31:0]   avl_writedata;
  logic [31:0]   avl_readdata;
  logic          avl_irq;

  int errors;
  int checks;

  input_irq_controller #(
    .NUM_INPUTS     (N),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .inputs       (inputs),
    .avl_address  (avl_address),
    .avl_read     (avl_read),
    .avl_write    (avl_write),
    .avl_writedata(avl_writedata),
    .avl_readdata (avl_readdata),
    .avl_irq      (avl_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // All stimulus changes and samples happen on the falling edge.
  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    avl_address = addr;
    avl_read    = 1'b1;
    @(negedge clk);
    data     = avl_readdata;
    avl_read = 1'b0;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    avl_address   = addr;
    avl_writedata = data;
    avl_write     = 1'b1;
    @(negedge clk);
    avl_write = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 0", avl_irq);
    end
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%0d: got %h expected 00000000", a, rd);
      end
    end
  endtask

  task automatic test_register_access();
    logic [31:0] rd;
    bus_write(A_MASK, 32'hFFFF_FFFF);
    bus_read(A_MASK, rd);
    checks++;
    if (rd !== 32'h3F) begin
      errors++;
      $display("FAIL mask_width: got %h expected 0000003f", rd);
    end
    bus_write(A_RISE, 32'h0000_00AA);
    bus_read(A_RISE, rd);
    checks++;
    if (rd !== 32'h2A) begin
      errors++;
      $display("FAIL rise_en_rw: got %h expected 0000002a", rd);
    end
    bus_write(A_FALL, 32'h0000_0015);
    bus_read(A_FALL, rd);
    checks++;
    if (rd !== 32'h15) begin
      errors++;
      $display("FAIL fall_en_rw: got %h expected 00000015", rd);
    end
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL reserved_addr6: got %h expected 00000000", rd);
    end
    bus_write(A_DATA, 32'h3F);
    bus_read(A_DATA, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL data_read_only: got %h expected 00000000", rd);
    end
    bus_write(A_MASK, 32'h0);
    bus_write(A_RISE, 32'h0);
    bus_write(A_FALL, 32'h0);
  endtask

  task automatic test_rise_capture();
    logic [31:0] rd;
    bus_write(A_RISE, 32'h01);
    bus_write(A_MASK, 32'h01);
    inputs = 6'h01;
    repeat (5) @(negedge clk);
    bus_read(A_DATA, rd);   // sampled at edge 6: level updates on that edge
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL rise_data_early: got %h expected 00000000", rd);
    end
    bus_read(A_DATA, rd);   // edge 7
    checks++;
    if (rd !== 32'h01) begin
      errors++;
      $display("FAIL rise_data: got %h expected 00000001", rd);
    end
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL rise_irq_early: got %b expected 0", avl_irq);
    end
    bus_read(A_EDGE, rd);   // edge 8
    checks++;
    if (rd !== 32'h01) begin
      errors++;
      $display("FAIL rise_edge_cap: got %h expected 00000001", rd);
    end
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL rise_irq: got %b expected 1", avl_irq);
    end
    bus_write(A_EDGE, 32'h01);
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_irq_hold: got %b expected 1", avl_irq);
    end
    @(negedge clk);
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_irq_clear: got %b expected 0", avl_irq);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] rd;
    bus_write(A_RISE, 32'h3F);
    inputs = 6'h03;
    repeat (2) @(negedge clk);
    bus_read(A_RAW, rd);
    inputs = 6'h01;         // bit 1 was high for three clocks
    checks++;
    if (rd !== 32'h03) begin
      errors++;
      $display("FAIL glitch_raw: got %h expected 00000003", rd);
    end
    repeat (10) @(negedge clk);
    bus_read(A_DATA, rd);
    checks++;
    if (rd !== 32'h01) begin
      errors++;
      $display("FAIL glitch_data: got %h expected 00000001", rd);
    end
    bus_read(A_EDGE, rd);
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL glitch_edge_cap: got %h expected 00000000", rd);
    end
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL glitch_irq: got %b expected 0", avl_irq);
    end
  endtask

  task automatic test_fall_mask();
    logic [31:0] rd;
    bus_write(A_RISE, 32'h00);
    bus_write(A_MASK, 32'h00);
    inputs = 6'h05;
    repeat (10) @(negedge clk);
    bus_write(A_FALL, 32'h04);
    inputs = 6'h01;
    repeat (10) @(negedge clk);
    bus_read(A_EDGE, rd);
    checks++;
    if (rd !== 32'h04) begin
      errors++;
      $display("FAIL fall_edge_cap: got %h expected 00000004", rd);
    end
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL fall_irq_masked: got %b expected 0", avl_irq);
    end
    bus_write(A_MASK, 32'h04);
    checks++;
    if (avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL mask_irq_early: got %b expected 0", avl_irq);
    end
    @(negedge clk);
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL mask_irq: got %b expected 1", avl_irq);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    bus_write(A_RISE, 32'h01);
    bus_write(A_MASK, 32'h05);
    inputs = 6'h00;
    repeat (10) @(negedge clk);
    inputs = 6'h01;
    repeat (6) @(negedge clk);
    // Capture of bit 0 lands on the same edge as this W1C of bits 0 and 2.
    bus_write(A_EDGE, 32'h05);
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL race_irq_a: got %b expected 1", avl_irq);
    end
    @(negedge clk);
    checks++;
    if (avl_irq !== 1'b1) begin
      errors++;
      $display("FAIL race_irq_b: got %b expected 1", avl_irq);
    end
    bus_read(A_EDGE, rd);
    checks++;
    if (rd !== 32'h01) begin
      errors++;
      $display("FAIL race_edge_cap: got %h expected 00000001", rd);
    end
  endtask

  task automatic test_read_write_same_cycle();
    logic [31:0] rd;
    avl_address   = A_MASK;
    avl_writedata = 32'h3F;
    avl_read      = 1'b1;
    avl_write     = 1'b1;
    @(negedge clk);
    avl_read  = 1'b0;
    avl_write = 1'b0;
    checks++;
    if (avl_readdata !== 32'h05) begin
      errors++;
      $display("FAIL rw_old_value: got %h expected 00000005", avl_readdata);
    end
    bus_read(A_MASK, rd);
    checks++;
    if (rd !== 32'h3F) begin
      errors++;
      $display("FAIL rw_new_value: got %h expected 0000003f", rd);
    end
  endtask

  task automatic test_reset_mid_debounce();
    logic [31:0] rd;
    logic [2:0]  regs [4];
    inputs = 6'h3F;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (avl_irq !== 1'b0 || avl_readdata !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: got irq=%b rd=%h expected irq=0 rd=00000000",
               avl_irq, avl_readdata);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    regs = '{A_MASK, A_EDGE, A_RISE, A_FALL};
    for (int k = 0; k < 4; k++) begin
      bus_read(regs[k], rd);
      checks++;
      if (rd !== 32'h0) begin
        errors++;
        $display("FAIL post_reset addr=%0d: got %h expected 00000000", regs[k], rd);
      end
    end
    bus_read(A_RAW, rd);    // edge 5
    checks++;
    if (rd !== 32'h3F) begin
      errors++;
      $display("FAIL post_reset_raw: got %h expected 0000003f", rd);
    end
    bus_read(A_DATA, rd);   // edge 6
    checks++;
    if (rd !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_data_early: got %h expected 00000000", rd);
    end
    bus_read(A_DATA, rd);   // edge 7
    checks++;
    if (rd !== 32'h3F) begin
      errors++;
      $display("FAIL post_reset_data: got %h expected 0000003f", rd);
    end
    repeat (3) @(negedge clk);
    bus_read(A_EDGE, rd);
    checks++;
    if (rd !== 32'h0 || avl_irq !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_no_capture: got edge=%h irq=%b expected 00000000 0",
               rd, avl_irq);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset_n       = 1'b0;
    inputs        = '0;
    avl_address   = '0;
    avl_read      = 1'b0;
    avl_write     = 1'b0;
    avl_writedata = '0;
    @(negedge clk);
    test_reset();
    test_register_access();
    test_rise_capture();
    test_glitch();
    test_fall_mask();
    test_w1c_race();
    test_read_write_same_cycle();
    test_reset_mid_debounce();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
